// File: rtl/alu_pipe.sv
// Single-issue ALU with a registered result stage and an optional shift-add multiplier.
// Define ALU_PIPE_MUL_EN to build the multiplier (MUL/MULHU); otherwise those ops act as reserved.
//
// state | meaning
// IDLE  | no result pending, ready for an op
// HOLD  | result held on y/taken with out_valid high until out_ready
// MUL   | multiplier iterating, one multiplier bit per cycle (ALU_PIPE_MUL_EN only)
module alu_pipe #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] y,
    output logic            taken,
    output logic            busy
);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_SLL   = 5'd2;
    localparam logic [4:0] OP_SLT   = 5'd3;
    localparam logic [4:0] OP_SLTU  = 5'd4;
    localparam logic [4:0] OP_XOR   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_OR    = 5'd8;
    localparam logic [4:0] OP_AND   = 5'd9;
    localparam logic [4:0] OP_BEQ   = 5'd10;
    localparam logic [4:0] OP_BNE   = 5'd11;
    localparam logic [4:0] OP_BLT   = 5'd12;
    localparam logic [4:0] OP_BGE   = 5'd13;
    localparam logic [4:0] OP_BLTU  = 5'd14;
    localparam logic [4:0] OP_BGEU  = 5'd15;
`ifdef ALU_PIPE_MUL_EN
    localparam logic [4:0] OP_MUL   = 5'd16;
    localparam logic [4:0] OP_MULHU = 5'd17;
`endif

`ifdef ALU_PIPE_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_MUL} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_HOLD} state_t;
`endif

    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   y_q, y_d;
    logic              taken_q, taken_d;

    logic [XLEN-1:0]   alu_y;
    logic              alu_taken;
    logic              is_branch;
    logic              br_cond;
    logic [SHW-1:0]    shamt;
    logic              accept;

`ifdef ALU_PIPE_MUL_EN
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic              mul_hi_q, mul_hi_d;
    logic [XLEN:0]     partial;
    logic [2*XLEN-1:0] acc_nxt;
    logic              is_mul_op;
`endif

    assign shamt = b[SHW-1:0];

    always_comb begin
        alu_y     = '0;
        alu_taken = 1'b0;
        is_branch = 1'b0;
        br_cond   = 1'b0;
        case (op)
            OP_ADD:  alu_y = a + b;
            OP_SUB:  alu_y = a - b;
            OP_SLL:  alu_y = a << shamt;
            OP_SLT:  alu_y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_y = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:  alu_y = a ^ b;
            OP_SRL:  alu_y = a >> shamt;
            OP_SRA:  alu_y = $signed(a) >>> shamt;
            OP_OR:   alu_y = a | b;
            OP_AND:  alu_y = a & b;
            OP_BEQ:  begin is_branch = 1'b1; br_cond = (a == b); end
            OP_BNE:  begin is_branch = 1'b1; br_cond = (a != b); end
            OP_BLT:  begin is_branch = 1'b1; br_cond = ($signed(a) < $signed(b)); end
            OP_BGE:  begin is_branch = 1'b1; br_cond = ($signed(a) >= $signed(b)); end
            OP_BLTU: begin is_branch = 1'b1; br_cond = (a < b); end
            OP_BGEU: begin is_branch = 1'b1; br_cond = (a >= b); end
            default: ;
        endcase
        if (is_branch) begin
            alu_taken = br_cond;
            alu_y     = br_cond ? (pc + imm) : (pc + XLEN'(4));
        end
    end

    assign in_ready = reset && ((state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready));
    assign accept   = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
    assign is_mul_op = (op == OP_MUL) || (op == OP_MULHU);
    // Add the multiplicand into the high half when the current multiplier bit is set, then shift right.
    assign partial   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? mcand_q : {XLEN{1'b0}})};
    assign acc_nxt   = {partial, acc_q[XLEN-1:1]};
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        taken_d     = taken_q;
`ifdef ALU_PIPE_MUL_EN
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        cnt_d       = cnt_q;
        mul_hi_d    = mul_hi_q;
`endif
        case (state_q)
            S_IDLE, S_HOLD: begin
                if ((state_q == S_HOLD) && out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    state_d     = S_HOLD;
                    out_valid_d = 1'b1;
                    y_d         = alu_y;
                    taken_d     = alu_taken;
`ifdef ALU_PIPE_MUL_EN
                    if (is_mul_op) begin
                        state_d     = S_MUL;
                        out_valid_d = 1'b0;
                        y_d         = y_q;
                        taken_d     = 1'b0;
                        acc_d       = {{XLEN{1'b0}}, b};
                        mcand_d     = a;
                        cnt_d       = SHW'(XLEN - 1);
                        mul_hi_d    = (op == OP_MULHU);
                    end
`endif
                end
            end
`ifdef ALU_PIPE_MUL_EN
            S_MUL: begin
                acc_d = acc_nxt;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == '0) begin
                    state_d     = S_HOLD;
                    out_valid_d = 1'b1;
                    taken_d     = 1'b0;
                    y_d         = mul_hi_q ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
                end
            end
`endif
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            taken_q     <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
            acc_q       <= '0;
            mcand_q     <= '0;
            cnt_q       <= '0;
            mul_hi_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            taken_q     <= taken_d;
`ifdef ALU_PIPE_MUL_EN
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            cnt_q       <= cnt_d;
            mul_hi_q    <= mul_hi_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign taken     = taken_q;
`ifdef ALU_PIPE_MUL_EN
    assign busy      = (state_q == S_MUL);
`else
    assign busy      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (XLEN=32); multiplier tests run only when ALU_PIPE_MUL_EN is defined.
module tb_alu_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] a, b, pc, imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        taken;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;
    int consumed = 0;
    int accepted = 0;

    logic [4:0]  v_op  [0:10];
    logic [31:0] v_a   [0:10];
    logic [31:0] v_b   [0:10];
    logic [31:0] v_y   [0:10];

    logic [4:0]  br_op [0:5];
    logic [31:0] br_a  [0:5];
    logic [31:0] br_b  [0:5];
    logic [31:0] br_pc [0:5];
    logic [31:0] br_im [0:5];
    logic [31:0] br_y  [0:5];
    logic        br_t  [0:5];

    alu_pipe #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .pc(pc), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .taken(taken), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset && out_valid && out_ready) consumed <= consumed + 1;
        if (in_valid && in_ready) accepted <= accepted + 1;
    end

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b1; op = 5'd0; a = 32'd3; b = 32'd4;
        pc = '0; imm = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset in_ready: got %b expected 0", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b expected 0", out_valid); else pass_cnt++;
        total_cnt++; if (y !== 32'd0) $display("FAIL reset y: got %h expected 00000000", y); else pass_cnt++;
        total_cnt++; if (taken !== 1'b0) $display("FAIL reset taken: got %b expected 0", taken); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", busy); else pass_cnt++;
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL post-reset in_ready: got %b expected 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_arith();
        v_op = '{5'd0, 5'd1, 5'd7, 5'd3, 5'd4, 5'd2, 5'd6, 5'd5, 5'd8, 5'd9, 5'd20};
        v_a  = '{32'hFFFFFFFF, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,
                 32'h80000000, 32'h0000F0F0, 32'h0000F000, 32'h0000FF00, 32'h5};
        v_b  = '{32'h1, 32'h1, 32'h21, 32'h1, 32'h1, 32'h24,
                 32'h1F, 32'h00000FF0, 32'h0000000F, 32'h00000FF0, 32'h6};
        v_y  = '{32'h0, 32'hFFFFFFFF, 32'hC0000000, 32'h1, 32'h0, 32'h10,
                 32'h1, 32'h0000FF00, 32'h0000F00F, 32'h00000F00, 32'h0};
        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1; op = v_op[i]; a = v_a[i]; b = v_b[i]; pc = 32'h40; imm = 32'h8; out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            total_cnt++; if (out_valid !== 1'b1) $display("FAIL arith out_valid vec %0d: got %b expected 1", i, out_valid); else pass_cnt++;
            total_cnt++; if (y !== v_y[i]) $display("FAIL arith y vec %0d: got %h expected %h", i, y, v_y[i]); else pass_cnt++;
            total_cnt++; if (taken !== 1'b0) $display("FAIL arith taken vec %0d: got %b expected 0", i, taken); else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL arith drain out_valid: got %b expected 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_branch();
        br_op = '{5'd12, 5'd15, 5'd10, 5'd11, 5'd13, 5'd14};
        br_a  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF};
        br_b  = '{32'h0, 32'h0, 32'h2, 32'h2, 32'h0, 32'h0};
        br_pc = '{32'h100, 32'h100, 32'h100, 32'h200, 32'h100, 32'h100};
        br_im = '{32'hFFFFFFF8, 32'hFFFFFFF8, 32'hFFFFFFF8, 32'h10, 32'hFFFFFFF8, 32'hFFFFFFF8};
        br_y  = '{32'hF8, 32'hF8, 32'h104, 32'h210, 32'h104, 32'h104};
        br_t  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; op = br_op[i]; a = br_a[i]; b = br_b[i]; pc = br_pc[i]; imm = br_im[i]; out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            total_cnt++; if (taken !== br_t[i]) $display("FAIL branch taken vec %0d: got %b expected %b", i, taken, br_t[i]); else pass_cnt++;
            total_cnt++; if (y !== br_y[i]) $display("FAIL branch y vec %0d: got %h expected %h", i, y, br_y[i]); else pass_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int c0, a0;
        c0 = consumed; a0 = accepted;
        in_valid = 1'b1; op = 5'd0; a = 32'h1; b = 32'h10; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total_cnt++; if (y !== 32'h11) $display("FAIL b2b first y: got %h expected 00000011", y); else pass_cnt++;
        a = 32'h2; out_ready = 1'b0;
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b stall in_ready c2: got %b expected 0", in_ready); else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        total_cnt++; if (y !== 32'h11) $display("FAIL b2b held y c3: got %h expected 00000011", y); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b held out_valid c3: got %b expected 1", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b stall in_ready c3: got %b expected 0", in_ready); else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        total_cnt++; if (y !== 32'h11) $display("FAIL b2b held y c4: got %h expected 00000011", y); else pass_cnt++;
        out_ready = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b resume in_ready: got %b expected 1", in_ready); else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        total_cnt++; if (y !== 32'h12) $display("FAIL b2b second y: got %h expected 00000012", y); else pass_cnt++;
        a = 32'h3;
        @(posedge clk);
        @(negedge clk);
        total_cnt++; if (y !== 32'h13) $display("FAIL b2b third y: got %h expected 00000013", y); else pass_cnt++;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b drain out_valid: got %b expected 0", out_valid); else pass_cnt++;
        total_cnt++; if (consumed - c0 !== 3) $display("FAIL b2b results consumed: got %0d expected 3", consumed - c0); else pass_cnt++;
        total_cnt++; if (accepted - a0 !== 3) $display("FAIL b2b ops accepted: got %0d expected 3", accepted - a0); else pass_cnt++;
    endtask

`ifdef ALU_PIPE_MUL_EN
    task automatic test_mul();
        logic [4:0]  m_op [0:3];
        logic [31:0] m_a  [0:3];
        logic [31:0] m_b  [0:3];
        logic [31:0] m_y  [0:3];
        int cyc;
        m_op = '{5'd17, 5'd16, 5'd16, 5'd17};
        m_a  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'h80000000};
        m_b  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd6, 32'h4};
        m_y  = '{32'hFFFFFFFE, 32'h00000001, 32'd42, 32'h2};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; op = m_op[i]; a = m_a[i]; b = m_b[i]; out_ready = 1'b1;
            @(posedge clk);
            cyc = 1;
            @(negedge clk);
            op = 5'd0; a = 32'h5; b = 32'h5;
            #1;
            total_cnt++; if (busy !== 1'b1) $display("FAIL mul busy vec %0d: got %b expected 1", i, busy); else pass_cnt++;
            total_cnt++; if (in_ready !== 1'b0) $display("FAIL mul in_ready vec %0d: got %b expected 0", i, in_ready); else pass_cnt++;
            while (out_valid !== 1'b1 && cyc < 100) begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
            end
            in_valid = 1'b0;
            total_cnt++; if (cyc != 33) $display("FAIL mul latency vec %0d: got %0d expected 33", i, cyc); else pass_cnt++;
            total_cnt++; if (y !== m_y[i]) $display("FAIL mul y vec %0d: got %h expected %h", i, y, m_y[i]); else pass_cnt++;
            total_cnt++; if (busy !== 1'b0) $display("FAIL mul busy done vec %0d: got %b expected 0", i, busy); else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_mul_reset();
        int seen;
        in_valid = 1'b1; op = 5'd17; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL mulrst out_valid: got %b expected 0", out_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL mulrst busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL mulrst in_ready in reset: got %b expected 0", in_ready); else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL mulrst in_ready idle: got %b expected 1", in_ready); else pass_cnt++;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        total_cnt++; if (seen != 0) $display("FAIL mulrst stale out_valid: got %0d cycles expected 0", seen); else pass_cnt++;
    endtask
`else
    task automatic test_mul_disabled();
        for (int i = 16; i < 18; i++) begin
            in_valid = 1'b1; op = 5'(i); a = 32'h7; b = 32'h6; out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            total_cnt++; if (out_valid !== 1'b1) $display("FAIL nomul out_valid op %0d: got %b expected 1", i, out_valid); else pass_cnt++;
            total_cnt++; if (y !== 32'h0) $display("FAIL nomul y op %0d: got %h expected 00000000", i, y); else pass_cnt++;
            total_cnt++; if (busy !== 1'b0) $display("FAIL nomul busy op %0d: got %b expected 0", i, busy); else pass_cnt++;
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_arith();
        test_branch();
        test_back_to_back();
`ifdef ALU_PIPE_MUL_EN
        test_mul();
        test_mul_reset();
`else
        test_mul_disabled();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
